// File: rtl/rob_commit.sv
// rob_commit - retire end of the reorder buffer.
//
// Rows of NBANK uops are allocated at the tail by dispatch, slots are marked
// complete by writeback, and the head row retires in program order once all
// of its valid slots are done. A completed excepting slot retires only the
// older slots of its row, then the whole buffer is flushed for one cycle.
//
// Ports:
//   i_clk, i_rst                 clock, async active-high reset
//   i_disp_we/val/uops           dispatch one row at the tail
//   o_disp_ready, o_disp_tag     tail can accept a row / tail row index
//   i_wb_en/tag/exc              writeback {row,slot}, exception flag
//   o_commit_en/mask/uops/tag    head row retirement
//   o_flush, o_exc_tag           one-cycle flush and the excepting {row,slot}
//   o_empty, o_full              occupancy flags
module rob_commit #(
    parameter int NBANK  = 4,
    parameter int ROWS   = 16,
    parameter int ROW_W  = $clog2(ROWS),
    parameter int BANK_W = $clog2(NBANK),
    parameter int UOPW   = 7
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_disp_we,
    input  logic [NBANK-1:0]        i_disp_val,
    input  logic [NBANK*UOPW-1:0]   i_disp_uops,
    output logic                    o_disp_ready,
    output logic [ROW_W-1:0]        o_disp_tag,
    input  logic                    i_wb_en,
    input  logic [ROW_W+BANK_W-1:0] i_wb_tag,
    input  logic                    i_wb_exc,
    output logic                    o_commit_en,
    output logic [NBANK-1:0]        o_commit_mask,
    output logic [NBANK*UOPW-1:0]   o_commit_uops,
    output logic [ROW_W-1:0]        o_commit_tag,
    output logic                    o_flush,
    output logic [ROW_W+BANK_W-1:0] o_exc_tag,
    output logic                    o_empty,
    output logic                    o_full
);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    logic [ROWS-1:0][NBANK-1:0]      val_q, val_d, busy_q, busy_d, exc_q, exc_d;
    logic [ROWS-1:0][NBANK*UOPW-1:0] uop_q, uop_d;
    logic [ROW_W-1:0]                head_q, head_d, tail_q, tail_d;
    logic [ROW_W:0]                  cnt_q, cnt_d;
    logic [0:0]                      state_q, state_d;
    logic [ROW_W+BANK_W-1:0]         exc_tag_q, exc_tag_d;

    logic [NBANK-1:0]  hv, hb, he;
    logic              e_found, blocked, commit, disp_fire, wb_ok;
    logic [BANK_W-1:0] e_idx;
    logic [NBANK-1:0]  older_mask;
    logic [ROW_W-1:0]  wb_row, wb_off;
    logic [BANK_W-1:0] wb_slot;

    assign hv = val_q[head_q];
    assign hb = busy_q[head_q];
    assign he = exc_q[head_q];

    // Oldest completed excepting slot, and whether anything that must retire
    // before it (or the whole row, if none) is still in flight.
    always_comb begin
        e_found    = 1'b0;
        e_idx      = '0;
        blocked    = 1'b0;
        older_mask = '0;
        for (int i = NBANK - 1; i >= 0; i--) begin
            if (hv[i] && !hb[i] && he[i]) begin
                e_found = 1'b1;
                e_idx   = BANK_W'(i);
            end
        end
        for (int i = 0; i < NBANK; i++) begin
            if (!e_found || i < int'(e_idx)) begin
                older_mask[i] = 1'b1;
                if (hv[i] && hb[i]) blocked = 1'b1;
            end
        end
    end

    assign o_empty       = (cnt_q == '0);
    assign o_full        = (cnt_q == (ROW_W+1)'(ROWS));
    assign o_disp_ready  = (state_q == RUN) && !o_full;
    assign o_disp_tag    = tail_q;
    assign o_flush       = (state_q == FLUSH);
    assign o_exc_tag     = exc_tag_q;
    assign o_commit_tag  = head_q;
    assign o_commit_uops = uop_q[head_q];

    // An excepting row always holds a valid slot, so count>0 is implied there.
    assign commit        = (state_q == RUN) && !blocked && (e_found || !o_empty);
    assign o_commit_en   = commit;
    assign o_commit_mask = commit ? (hv & older_mask) : '0;

    assign disp_fire = i_disp_we && o_disp_ready;
    assign wb_row    = i_wb_tag[ROW_W+BANK_W-1:BANK_W];
    assign wb_slot   = i_wb_tag[BANK_W-1:0];
    assign wb_off    = wb_row - head_q;
    // Allocated = distance from head (mod ROWS) below the occupancy count.
    assign wb_ok     = i_wb_en && (state_q == RUN) && ({1'b0, wb_off} < cnt_q)
                       && (int'(wb_slot) < NBANK) && val_q[wb_row][wb_slot];

    always_comb begin
        val_d     = val_q;
        busy_d    = busy_q;
        exc_d     = exc_q;
        uop_d     = uop_q;
        head_d    = head_q;
        tail_d    = tail_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        exc_tag_d = exc_tag_q;
        if (state_q == FLUSH) begin
            val_d   = '0;
            busy_d  = '0;
            exc_d   = '0;
            tail_d  = head_q;
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            if (wb_ok) begin
                busy_d[wb_row][wb_slot] = 1'b0;
                exc_d[wb_row][wb_slot]  = i_wb_exc;
            end
            if (commit) begin
                val_d[head_q]  = '0;
                busy_d[head_q] = '0;
                exc_d[head_q]  = '0;
                // head moves past the excepting row so refill starts after it
                head_d         = head_q + 1'b1;
                if (e_found) begin
                    state_d   = FLUSH;
                    exc_tag_d = {head_q, e_idx};
                end
            end
            if (disp_fire) begin
                val_d[tail_q]  = i_disp_val;
                busy_d[tail_q] = i_disp_val;
                exc_d[tail_q]  = '0;
                uop_d[tail_q]  = i_disp_uops;
                tail_d         = tail_q + 1'b1;
            end
            cnt_d = cnt_q + (ROW_W+1)'(disp_fire) - (ROW_W+1)'(commit);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            val_q     <= '0;
            busy_q    <= '0;
            exc_q     <= '0;
            uop_q     <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            state_q   <= RUN;
            exc_tag_q <= '0;
        end else begin
            val_q     <= val_d;
            busy_q    <= busy_d;
            exc_q     <= exc_d;
            uop_q     <= uop_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            exc_tag_q <= exc_tag_d;
        end
    end
endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
- Retire (reader) end of the reorder buffer.
- Dispatch writes one row of NBANK uops per cycle at the tail. Execution writeback clears busy bits per slot. This block retires the head row in program order once every valid slot in it has completed.
- When a completed slot carries an exception, the block retires the older slots of that row, then flushes the whole buffer for one cycle and reports the excepting tag.

Parameters:
- NBANK, 4, slots per row (dispatch width)
- ROWS, 16, number of rows; must be a power of two
- ROW_W, $clog2(ROWS), row index width
- BANK_W, $clog2(NBANK), slot index width
- UOPW, 7, uop opcode width

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- i_disp_we  input  1  dispatch a row at the tail; honoured only when o_disp_ready=1
- i_disp_val  input  NBANK  per-slot valid for the dispatched row
- i_disp_uops  input  NBANK*UOPW  uops packed; slot 0 in the LSBs
- o_disp_ready  output  1  row free and state RUN
- o_disp_tag  output  ROW_W  current tail row index
- i_wb_en  input  1  writeback strobe
- i_wb_tag  input  ROW_W+BANK_W  {row, slot} of the completing uop
- i_wb_exc  input  1  completing uop raised an exception
- o_commit_en  output  1  retire this cycle
- o_commit_mask  output  NBANK  slots retired this cycle
- o_commit_uops  output  NBANK*UOPW  uops of the head row
- o_commit_tag  output  ROW_W  head row index
- o_flush  output  1  one-cycle flush pulse
- o_exc_tag  output  ROW_W+BANK_W  {row, slot} of the excepting uop; valid while o_flush=1
- o_empty  output  1  count==0
- o_full  output  1  count==ROWS

Behaviour:
- State per slot: val, busy, exc, uop. Pointers: head and tail (ROW_W bits, wrap modulo ROWS). Count is ROW_W+1 bits.
- Reset (asynchronous): head=tail=count=0; all val/busy/exc=0; state RUN. Output values: o_disp_ready=1, o_empty=1, o_full=0, o_commit_en=0, o_commit_mask=0, o_flush=0, o_exc_tag=0, o_disp_tag=0.
- Dispatch: on an edge with i_disp_we and o_disp_ready, row[tail] is written as follows, then tail++ and count++:
  - val = i_disp_val
  - busy = i_disp_val
  - exc = 0
  - uops = i_disp_uops
- A dispatched row with i_disp_val=0 is still allocated. It is retired with o_commit_mask=0.
- o_disp_ready = (state==RUN) && !o_full. It is derived from registered state only, so a commit in the same cycle does not unblock a full buffer until the next cycle.
- Writeback: on an edge with i_wb_en and state RUN, busy of the addressed slot is cleared and exc is set to i_wb_exc.
  - The write applies only when the row is allocated and the slot is valid; otherwise it is ignored.
  - A repeated writeback to an already completed slot overwrites exc.
- Commit decisions are combinational from registered state. Head advances at the edge.
  - Let E = the lowest slot index with val&!busy&exc.
  - Let B = true if any valid slot with an index below E (or any valid slot at all, when there is no E) is still busy.
  - No E, B false, count>0: o_commit_en=1 and o_commit_mask=val. At the edge the row is cleared, head++ and count--.
  - E exists, B false: o_commit_en=1 and o_commit_mask=val & ((1<<E)-1). At the edge, o_exc_tag latches {head,E} and state moves to FLUSH.
  - Otherwise: o_commit_en=0 and o_commit_mask=0.
- A writeback and a commit evaluation in the same cycle: the commit uses pre-edge busy, so the row retires at the earliest one cycle after the writeback edge.
- Dispatch and commit in the same cycle: both happen; count is unchanged.
- FLUSH state lasts exactly one cycle:
  - o_flush=1, o_commit_en=0, o_disp_ready=0.
  - Dispatch and writeback are ignored.
  - At the edge, all val/busy/exc are cleared, tail=head and count=0, and state returns to RUN.
  - head is not reset; the next dispatch lands at the row after the excepting row.
- o_exc_tag holds its last value outside FLUSH.
- Wrap-around: head and tail wrap from ROWS-1 to 0. Full/empty are distinguished by count, not by pointer equality.
- Reset asserted mid-operation (including during FLUSH) returns every register to its reset value immediately, independent of the clock.

Test Plan:
- Reset, then dispatch rows 0..15 with val=4'b1111 -> o_full=1, o_disp_ready=0. A further i_disp_we is ignored and tail stays 0.
- Dispatch row 0 with val=4'b0101, then writeback tags {0,0} and {0,2} with exc=0 -> o_commit_en=1, mask=4'b0101, o_commit_tag=0 in the cycle after the second writeback; o_empty=1 afterwards.
- Dispatch rows 0 and 1 (all valid). Complete row 1 fully and row 0 except slot 3 -> no commit. After writeback {0,3}: row 0 commits, then row 1 commits on the next cycle.
- Row 0 all valid. Writeback slots 0 and 1 with exc=0 and slot 2 with exc=1; slot 3 stays busy -> commit mask=4'b0011. Next cycle o_flush=1 and o_exc_tag={0,2}. Afterwards o_empty=1 and o_disp_tag=1.
- Dispatch 20 rows with a one-row-per-cycle commit stream -> tags wrap 15 to 0, retirement stays in order, and count never exceeds 16.
- Assert i_rst during FLUSH -> o_flush=0 immediately, head=tail=0 and o_disp_ready=1 without waiting for a clock edge.
